// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//
// Receives an instruction image over a byte stream (valid/ready handshake)
// and writes it word-by-word into the CPU instruction memory, holding the
// core in reset until the whole image has arrived with a matching checksum.
//
// Stream: N low byte, N high byte, N x 4-byte words (LSB first), 1 checksum
// byte. The checksum byte must equal the XOR of all header and data bytes.
//
// Parameters
//   MAX_WORDS  instruction-memory capacity in 32-bit words
//   TIMEOUT    maximum idle cycles between accepted bytes during a load
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         synchronous active-high reset
//   start       one-cycle request to begin a load (honoured in IDLE/DONE/ERR)
//   byte_valid  upstream byte present
//   byte_data   upstream byte
//   byte_ready  loader accepts a byte this cycle
//   wr_en_ins   instruction-memory write strobe (one cycle per word)
//   wr_data     instruction word being written (held between writes)
//   wr_addr     byte address of the word being written (held between writes)
//   cpu_rst_n   core reset, active-low; released only after a good load
//   done        load finished with a good checksum
//   error       load aborted (oversize, bad checksum or timeout)
// -----------------------------------------------------------------------------
module instr_loader #(
    parameter int unsigned MAX_WORDS = 1024,
    parameter int unsigned TIMEOUT   = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        wr_en_ins,
    output logic [31:0] wr_data,
    output logic [31:0] wr_addr,
    output logic        cpu_rst_n,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR_LO = 3'd1,
        HDR_HI = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        CHECK  = 3'd5,
        DONE   = 3'd6,
        ERR    = 3'd7
    } state_t;

    // Idle counter is wide enough to reach TIMEOUT exactly.
    localparam int IDLE_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT);

    state_t             state_reg;
    state_t             state_next;

    logic [15:0]        count_reg;      // N from the header
    logic [15:0]        word_idx_reg;   // words already written
    logic [1:0]         byte_cnt_reg;   // byte lane within the current word
    logic [7:0]         lane_reg [4];   // word assembly, one register per lane
    logic [7:0]         csum_reg;
    logic [IDLE_W-1:0]  idle_cnt_reg;
    logic [31:0]        wr_data_reg;
    logic [31:0]        wr_addr_reg;

    logic               xfer;
    logic               timed_out;
    logic               start_accept;
    logic               rx_state;
    logic [15:0]        n_hdr;

    assign xfer         = byte_valid && byte_ready;
    assign timed_out    = (idle_cnt_reg == IDLE_LIMIT);
    assign start_accept = start && ((state_reg == IDLE) || (state_reg == DONE) || (state_reg == ERR));
    assign rx_state     = (state_reg == HDR_LO) || (state_reg == HDR_HI) ||
                          (state_reg == DATA)   || (state_reg == CHECK);
    // Full word count as it becomes known on the high-byte transfer.
    assign n_hdr        = {byte_data, count_reg[7:0]};

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ----------------------------------------------------------- next state
    // A transfer is always checked before the timeout so a byte arriving on
    // the expiry cycle still counts.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE, DONE, ERR: begin
                if (start) state_next = HDR_LO;
            end
            HDR_LO: begin
                if (xfer)           state_next = HDR_HI;
                else if (timed_out) state_next = ERR;
            end
            HDR_HI: begin
                if (xfer) begin
                    if ({16'd0, n_hdr} > MAX_WORDS) state_next = ERR;
                    else if (n_hdr == 16'd0)        state_next = CHECK;
                    else                            state_next = DATA;
                end else if (timed_out) begin
                    state_next = ERR;
                end
            end
            DATA: begin
                if (xfer) begin
                    if (byte_cnt_reg == 2'd3) state_next = WRITE;
                end else if (timed_out) begin
                    state_next = ERR;
                end
            end
            WRITE: begin
                if ((word_idx_reg + 16'd1) == count_reg) state_next = CHECK;
                else                                     state_next = DATA;
            end
            CHECK: begin
                if (xfer) begin
                    if (byte_data == csum_reg) state_next = DONE;
                    else                       state_next = ERR;
                end else if (timed_out) begin
                    state_next = ERR;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        byte_ready = 1'b0;
        wr_en_ins  = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        cpu_rst_n  = 1'b0;
        unique case (state_reg)
            HDR_LO, HDR_HI, DATA, CHECK: byte_ready = 1'b1;
            WRITE:                       wr_en_ins  = 1'b1;
            DONE: begin
                done      = 1'b1;
                cpu_rst_n = 1'b1;
            end
            ERR:                         error      = 1'b1;
            default: ;
        endcase
    end

    assign wr_data = wr_data_reg;
    assign wr_addr = wr_addr_reg;

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg    <= '0;
            word_idx_reg <= '0;
            byte_cnt_reg <= '0;
            csum_reg     <= '0;
            idle_cnt_reg <= '0;
            wr_data_reg  <= '0;
            wr_addr_reg  <= '0;
        end else if (start_accept) begin
            word_idx_reg <= '0;
            byte_cnt_reg <= '0;
            csum_reg     <= '0;
            idle_cnt_reg <= '0;
        end else begin
            if (xfer) begin
                idle_cnt_reg <= '0;
                // The checksum byte itself is not folded into the accumulator.
                if (state_reg != CHECK) csum_reg <= csum_reg ^ byte_data;
                case (state_reg)
                    HDR_LO: count_reg[7:0]  <= byte_data;
                    HDR_HI: count_reg[15:8] <= byte_data;
                    DATA: begin
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        // Capture the finished word here so it is stable for
                        // the whole WRITE cycle and held afterwards.
                        if (byte_cnt_reg == 2'd3) begin
                            wr_data_reg <= {byte_data, lane_reg[2], lane_reg[1], lane_reg[0]};
                            wr_addr_reg <= {14'd0, word_idx_reg, 2'b00};
                        end
                    end
                    default: ;
                endcase
            end else if (rx_state && !timed_out) begin
                idle_cnt_reg <= idle_cnt_reg + 1'b1;
            end

            if (state_reg == WRITE) word_idx_reg <= word_idx_reg + 16'd1;
        end
    end

    // Byte lanes of the word under assembly; lane gi loads when byte_cnt==gi.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            always_ff @(posedge clk) begin
                if (rst) begin
                    lane_reg[gi] <= '0;
                end else if (xfer && (state_reg == DATA) && (byte_cnt_reg == 2'(gi))) begin
                    lane_reg[gi] <= byte_data;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_instr_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_loader -- directed self-checking bench for instr_loader.
// Inputs are driven 1 time unit after the rising edge; outputs are checked
// there as well, or at the falling edge for handshake sampling.
// The reference image is two words 0x12345678, 0xDEADBEEF; the XOR of its
// ten header and data bytes (02 00 78 56 34 12 EF BE AD DE) is 0x28.
// -----------------------------------------------------------------------------
module tb_instr_loader;

    localparam int unsigned TMO = 16;
    localparam logic [7:0]  GOOD_CSUM = 8'h28;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en_ins;
    logic [31:0] wr_data;
    logic [31:0] wr_addr;
    logic        cpu_rst_n;
    logic        done;
    logic        error;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_seen = 0;
    int wr_base;

    instr_loader #(
        .MAX_WORDS (1024),
        .TIMEOUT   (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .wr_en_ins  (wr_en_ins),
        .wr_data    (wr_data),
        .wr_addr    (wr_addr),
        .cpu_rst_n  (cpu_rst_n),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Count write strobes away from the active edge.
    always @(negedge clk) begin
        if (wr_en_ins === 1'b1) wr_seen <= wr_seen + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Offer one byte after 'gap' idle cycles; return 1 unit after it transfers.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        waited = 0;
        byte_valid = 1'b0;
        repeat (gap) step();
        byte_valid = 1'b1;
        byte_data  = b;
        forever begin
            @(negedge clk);
            if (byte_ready === 1'b1) break;
            waited++;
            if (waited > 50) begin
                n_cmp++;
                n_bad++;
                $display("FAIL byte_ready_wait: observed no ready in 50 cycles expected ready for byte %h", b);
                byte_valid = 1'b0;
                return;
            end
        end
        step();
        byte_valid = 1'b0;
    endtask

    // Send a word; the cycle right after its 4th byte must be the write.
    task automatic send_word(input logic [31:0] w, input logic [31:0] addr, input bit rnd);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], rnd ? int'($urandom_range(0, 3)) : 0);
        end
        check("wr_en_ins_write", wr_en_ins, 1'b1);
        check("wr_data_write",   wr_data,   w);
        check("wr_addr_write",   wr_addr,   addr);
    endtask

    task automatic load_image(input bit rnd, input logic [7:0] csum);
        send_byte(8'h02, rnd ? int'($urandom_range(0, 3)) : 0);
        send_byte(8'h00, rnd ? int'($urandom_range(0, 3)) : 0);
        send_word(32'h1234_5678, 32'h0, rnd);
        send_word(32'hDEAD_BEEF, 32'h4, rnd);
        send_byte(csum, rnd ? int'($urandom_range(0, 3)) : 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_byte_ready"}, byte_ready, 1'b0);
        check({tag, "_wr_en_ins"},  wr_en_ins,  1'b0);
        check({tag, "_wr_data"},    wr_data,    32'h0);
        check({tag, "_wr_addr"},    wr_addr,    32'h0);
        check({tag, "_cpu_rst_n"},  cpu_rst_n,  1'b0);
        check({tag, "_done"},       done,       1'b0);
        check({tag, "_error"},      error,      1'b0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) step();
        check_reset_outputs("reset");
        rst = 1'b0;
        step();

        // Good load, no backpressure, with a stray start in DATA.
        wr_base = wr_seen;
        do_start();
        check("hdr_lo_ready", byte_ready, 1'b1);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_word(32'h1234_5678, 32'h0, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("after_write_en",   wr_en_ins,  1'b0);
        check("after_write_data", wr_data,    32'h1234_5678);
        check("after_write_addr", wr_addr,    32'h0);
        check("start_ignored",    byte_ready, 1'b1);
        send_word(32'hDEAD_BEEF, 32'h4, 1'b0);
        send_byte(GOOD_CSUM, 0);
        check("good_done",      done,      1'b1);
        check("good_cpu_rst_n", cpu_rst_n, 1'b1);
        check("good_error",     error,     1'b0);
        check("good_ready",     byte_ready, 1'b0);
        repeat (3) step();
        check("good_done_hold", done, 1'b1);
        check("good_writes",    wr_seen - wr_base, 2);
        $display("good load: done=%0d cpu_rst_n=%0d writes=%0d", done, cpu_rst_n, wr_seen - wr_base);

        // Bad checksum; start from DONE must clear done/cpu_rst_n.
        wr_base = wr_seen;
        do_start();
        check("restart_done",      done,      1'b0);
        check("restart_cpu_rst_n", cpu_rst_n, 1'b0);
        load_image(1'b0, 8'h00);
        check("bad_error",     error,     1'b1);
        check("bad_done",      done,      1'b0);
        check("bad_cpu_rst_n", cpu_rst_n, 1'b0);
        check("bad_writes",    wr_seen - wr_base, 2);
        $display("bad checksum: error=%0d writes=%0d", error, wr_seen - wr_base);

        // Oversize header N=1025.
        wr_base = wr_seen;
        do_start();
        check("restart_error", error, 1'b0);
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        check("oversize_error", error, 1'b1);
        check("oversize_ready", byte_ready, 1'b0);
        repeat (2) step();
        check("oversize_writes", wr_seen - wr_base, 0);
        $display("oversize: error=%0d writes=%0d", error, wr_seen - wr_base);

        // N=1024 is exactly at capacity and must be accepted.
        do_start();
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        check("maxwords_error", error, 1'b0);
        check("maxwords_ready", byte_ready, 1'b1);
        $display("max words header: error=%0d ready=%0d", error, byte_ready);
        rst = 1'b1;
        step();
        rst = 1'b0;

        // Empty load.
        wr_base = wr_seen;
        do_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check("empty_in_check", byte_ready, 1'b1);
        send_byte(8'h00, 0);
        check("empty_done",   done, 1'b1);
        check("empty_writes", wr_seen - wr_base, 0);
        $display("empty load: done=%0d writes=%0d", done, wr_seen - wr_base);

        // Good load with random gaps between bytes.
        wr_base = wr_seen;
        do_start();
        load_image(1'b1, GOOD_CSUM);
        check("bp_done",      done,      1'b1);
        check("bp_cpu_rst_n", cpu_rst_n, 1'b1);
        check("bp_writes",    wr_seen - wr_base, 2);
        $display("backpressure load: done=%0d writes=%0d", done, wr_seen - wr_base);

        // Stall in DATA: still alive after TMO idle cycles, ERR one cycle later.
        do_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h78, 0);
        repeat (TMO) step();
        check("stall_not_yet", error, 1'b0);
        step();
        check("stall_timeout",       error,      1'b1);
        check("stall_timeout_ready", byte_ready, 1'b0);
        $display("timeout stall: error=%0d", error);

        // Reset during the second word, then a clean load.
        do_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_word(32'h1234_5678, 32'h0, 1'b0);
        send_byte(8'hEF, 0);
        send_byte(8'hBE, 0);
        rst   = 1'b1;
        start = 1'b1;
        step();
        rst   = 1'b0;
        start = 1'b0;
        check_reset_outputs("midreset");
        $display("mid-load reset: wr_data=%h done=%0d error=%0d", wr_data, done, error);
        wr_base = wr_seen;
        do_start();
        load_image(1'b0, GOOD_CSUM);
        check("reload_done",   done, 1'b1);
        check("reload_writes", wr_seen - wr_base, 2);
        $display("reload after reset: done=%0d writes=%0d", done, wr_seen - wr_base);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
